// File: rtl/banked_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | banked_regfile: ARM-style mode-banked r0-r14 plus PC, NUM_RD read ports,   |
// | one write port, registered/sticky error flags.                           |
// | Optional macro BANKED_RF_BYPASS_EN: same-cycle write-to-read forwarding.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module banked_regfile #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_RD   = 3,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*NUM_RD-1:0]      r_addr_i,
  output logic [DATA_W*NUM_RD-1:0] r_data_o,
  output logic [NUM_RD-1:0]        r_err_o,
  input  logic [3:0]               w_addr_i,
  input  logic [DATA_W-1:0]        w_data_i,
  input  logic                     write_reg_i,
  input  logic                     write_pc_i,
  input  logic [DATA_W-1:0]        pc_data_i,
  input  logic [4:0]               m_i,
  output logic                     err_w_o,
  output logic                     err_sticky_o,
  input  logic                     err_clr_i
);

`ifdef BANKED_RF_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // Physical map: 0-14 base, 15-21 fiq r8-r14, 22-27 r13 banks, 28-32 r14 banks.
  localparam int NUM_GPR = 33;

  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              err_w_q, err_w_d;
  logic              err_sticky_q, err_sticky_d;
  logic [5:0]        mode_dec;
  logic [6:0]        wr_map;
  logic [5:0]        wr_idx;
  logic              wr_legal;

  // Returns {valid, fiq, banked, bank[2:0]}; bank order irq,svc,mon,abt,und,hyp.
  function automatic logic [5:0] decode_mode(input logic [4:0] m);
    logic [5:0] r;
    r = '0;
    if (m[4]) begin
      case (m[3:0])
        4'b0000, 4'b1111: r = 6'b100_000;
        4'b0001:          r = 6'b110_000;
        4'b0010:          r = 6'b101_000;
        4'b0011:          r = 6'b101_001;
        4'b0110:          r = 6'b101_010;
        4'b0111:          r = 6'b101_011;
        4'b1011:          r = 6'b101_100;
        4'b1010:          r = 6'b101_101;
        default:          r = 6'b000_000;
      endcase
    end
    return r;
  endfunction

  // Returns {legal, physical index} for r0-r14; address 15 is handled by callers.
  function automatic logic [6:0] map_reg(input logic [3:0] a, input logic [4:0] m);
    logic [5:0] md;
    logic       ok;
    logic [5:0] idx;
    md  = decode_mode(m);
    ok  = 1'b1;
    idx = {2'b00, a};
    if (a >= 4'd8) begin
      if (!md[5]) begin
        ok = 1'b0;
      end else if (md[4]) begin
        idx = {2'b00, a} + 6'd7;
      end else if (md[3] && a == 4'd13) begin
        idx = 6'd22 + {3'b000, md[2:0]};
      end else if (md[3] && a == 4'd14) begin
        if (md[2:0] == 3'd5) ok = 1'b0;
        else                 idx = 6'd28 + {3'b000, md[2:0]};
      end
    end
    return {ok, idx};
  endfunction

  always_comb begin
    mode_dec     = decode_mode(m_i);
    wr_map       = map_reg(w_addr_i, m_i);
    wr_idx       = wr_map[5:0];
    wr_legal     = write_reg_i && mode_dec[5] && (w_addr_i != 4'd15) && wr_map[6];
    err_w_d      = write_reg_i && !wr_legal;
    err_sticky_d = err_clr_i ? 1'b0 : (err_sticky_q | err_w_d | (|r_err_o));
    pc_d         = write_pc_i ? pc_data_i : pc_q;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [3:0]        addr;
    logic [6:0]        map;
    logic [DATA_W-1:0] data;
    logic              err;

    assign addr = r_addr_i[4*k +: 4];

    always_comb begin
      map  = map_reg(addr, m_i);
      data = '0;
      err  = 1'b0;
      if (addr == 4'd15) begin
        data = (BYPASS_EN && write_pc_i && !rst) ? pc_data_i : pc_q;
      end else if (!map[6]) begin
        err = 1'b1;
      end else if (BYPASS_EN && wr_legal && !rst && map[5:0] == wr_idx) begin
        data = w_data_i;
      end else begin
        data = gpr_q[map[5:0]];
      end
    end

    assign r_data_o[DATA_W*k +: DATA_W] = data;
    assign r_err_o[k]                   = err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      pc_q         <= RESET_PC;
      err_w_q      <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      if (wr_legal) gpr_q[wr_idx] <= w_data_i;
      pc_q         <= pc_d;
      err_w_q      <= err_w_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_w_o      = err_w_q;
  assign err_sticky_o = err_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_banked_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_banked_regfile: randomized + directed bench for banked_regfile against |
// | a name-keyed register model.                                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_banked_regfile;
  localparam int          DW  = 32;
  localparam int          NR  = 3;
  localparam logic [31:0] RPC = 32'h0000_0080;

  localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010, SVC = 5'b10011;
  localparam logic [4:0] MON = 5'b10110, ABT = 5'b10111, HYP = 5'b11010, UND = 5'b11011;
  localparam logic [4:0] SYS = 5'b11111, BAD = 5'b10100;

  logic           clk;
  logic           rst;
  logic [4*NR-1:0] r_addr;
  logic [DW*NR-1:0] r_data;
  logic [NR-1:0]  r_err;
  logic [3:0]     w_addr;
  logic [DW-1:0]  w_data;
  logic           write_reg;
  logic           write_pc;
  logic [DW-1:0]  pc_data;
  logic [4:0]     m;
  logic           err_w;
  logic           err_sticky;
  logic           err_clr;

  banked_regfile #(.DATA_W(DW), .NUM_RD(NR), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .r_addr_i(r_addr), .r_data_o(r_data), .r_err_o(r_err),
    .w_addr_i(w_addr), .w_data_i(w_data), .write_reg_i(write_reg), .write_pc_i(write_pc),
    .pc_data_i(pc_data), .m_i(m), .err_w_o(err_w), .err_sticky_o(err_sticky),
    .err_clr_i(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mdl [string];
  logic [31:0] pc_m;
  logic        err_w_m;
  logic        sticky_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic string mode_name(input logic [4:0] mm);
    case (mm)
      USR: return "usr";  FIQ: return "fiq";  IRQ: return "irq";
      SVC: return "svc";  MON: return "mon";  ABT: return "abt";
      HYP: return "hyp";  UND: return "und";  SYS: return "sys";
      default: return "";
    endcase
  endfunction

  // Which bank owns register a in mode mn; "ILL" when the access is illegal.
  function automatic string owner(input int a, input string mn);
    if (a < 8) return "base";
    if (mn == "") return "ILL";
    if (mn == "usr" || mn == "sys") return "base";
    if (mn == "fiq") return "fiq";
    if (a == 13) return mn;
    if (a == 14) return (mn == "hyp") ? "ILL" : mn;
    return "base";
  endfunction

  function automatic logic [31:0] mget(input string key);
    return mdl.exists(key) ? mdl[key] : 32'h0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; write_reg = 1'b1; write_pc = 1'b1; w_addr = 4'd3;
    w_data = $urandom; pc_data = $urandom; m = USR; err_clr = 1'b0; r_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0; write_reg = 1'b0; write_pc = 1'b0;
    mdl.delete();
    pc_m = RPC; err_w_m = 1'b0; sticky_m = 1'b0;
    check("rst err_w", {31'b0, err_w}, 32'h0);
    check("rst err_sticky", {31'b0, err_sticky}, 32'h0);
  endtask

  task automatic cycle(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [4:0] mm, input logic wr, input logic [3:0] wa,
                       input logic [31:0] wd, input logic wpc, input logic [31:0] pcd,
                       input logic clr);
    logic [3:0]  ra [NR];
    string       mn, wown, wkey, own, key;
    logic        wlegal, any_err, ee;
    logic [31:0] ed;
    ra[0] = a0; ra[1] = a1; ra[2] = a2;
    r_addr = {a2, a1, a0}; m = mm; write_reg = wr; w_addr = wa; w_data = wd;
    write_pc = wpc; pc_data = pcd; err_clr = clr;
    #2;
    mn     = mode_name(mm);
    wown   = owner(int'(wa), mn);
    wkey   = $sformatf("%s_%0d", wown, wa);
    wlegal = wr && (mn != "") && (wa != 4'd15) && (wown != "ILL");
    any_err = 1'b0;
    for (int k = 0; k < NR; k++) begin
      ee = 1'b0;
      if (ra[k] == 4'd15) begin
        ed = pc_m;
`ifdef BANKED_RF_BYPASS_EN
        if (wpc) ed = pcd;
`endif
      end else begin
        own = owner(int'(ra[k]), mn);
        key = $sformatf("%s_%0d", own, ra[k]);
        if (own == "ILL") begin
          ed = 32'h0; ee = 1'b1;
        end else begin
          ed = mget(key);
`ifdef BANKED_RF_BYPASS_EN
          if (wlegal && key == wkey) ed = wd;
`endif
        end
      end
      any_err |= ee;
      check($sformatf("rd%0d a%0d m%b data", k, ra[k], mm), r_data[DW*k +: DW], ed);
      check($sformatf("rd%0d a%0d m%b err", k, ra[k], mm), {31'b0, r_err[k]}, {31'b0, ee});
    end
    @(posedge clk); #1;
    if (wlegal) mdl[wkey] = wd;
    if (wpc) pc_m = pcd;
    err_w_m  = wr && !wlegal;
    sticky_m = clr ? 1'b0 : (sticky_m | err_w_m | any_err);
    check($sformatf("err_w m%b wa%0d", mm, wa), {31'b0, err_w}, {31'b0, err_w_m});
    check($sformatf("err_sticky m%b clr%0d", mm, clr), {31'b0, err_sticky}, {31'b0, sticky_m});
    write_reg = 1'b0; write_pc = 1'b0; err_clr = 1'b0;
  endtask

  logic [4:0] modes [12];
  initial begin
    modes = '{USR, FIQ, IRQ, SVC, MON, ABT, HYP, UND, SYS, BAD, 5'b00000, 5'b11000};
    rst = 1'b1; r_addr = '0; w_addr = '0; w_data = '0; write_reg = 1'b0;
    write_pc = 1'b0; pc_data = '0; m = USR; err_clr = 1'b0;
    do_reset();

    for (int i = 0; i < 16; i += 3)
      cycle(4'(i), 4'((i + 1) % 16), 4'((i + 2) % 16), USR, 0, 0, 0, 0, 0, 0);

    cycle(13, 13, 13, USR, 1, 13, 32'hAAAA_0001, 0, 0, 0);
    cycle(13, 13, 13, SVC, 1, 13, 32'h5555_0002, 0, 0, 0);
    cycle(13, 14, 13, USR, 0, 0, 0, 0, 0, 0);
    cycle(13, 14, 13, SVC, 0, 0, 0, 0, 0, 0);
    cycle(13, 14, 13, SYS, 0, 0, 0, 0, 0, 0);

    cycle(8, 7, 8, FIQ, 1, 8, 32'h1234_5678, 0, 0, 0);
    cycle(8, 7, 8, USR, 1, 7, 32'h7777_0007, 0, 0, 0);
    cycle(8, 7, 14, FIQ, 0, 0, 0, 0, 0, 0);

    cycle(0, 1, 15, USR, 1, 15, 32'hBAD0_BAD0, 0, 0, 0);
    cycle(0, 1, 15, USR, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 15, USR, 0, 0, 0, 0, 0, 1);
    cycle(14, 13, 3, HYP, 1, 14, 32'h1111_2222, 0, 0, 0);
    cycle(9, 3, 15, BAD, 0, 0, 0, 0, 0, 1);
    cycle(3, 3, 3, BAD, 1, 3, 32'h3333_3333, 0, 0, 1);

    cycle(2, 15, 2, USR, 1, 2, 32'h0000_DEAD, 1, 32'h0000_0100, 0);
    cycle(2, 15, 2, USR, 0, 0, 0, 0, 0, 0);

    cycle(0, 0, 0, USR, 1, 15, 32'h0, 0, 0, 1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(4'($urandom), 4'($urandom), 4'($urandom), modes[$urandom_range(0, 11)],
            1'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 3) == 0),
            $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
